// File: rtl/icache_refill_sequencer.sv
// Instruction-cache line refill sequencer: issues per-word reads, collects in-order responses
// into a line buffer and hands the line to the array updater. Define ICACHE_REFILL_CWF_EN for
// critical-word-first wrap order with early critical-word delivery.
module icache_refill_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic                                 clk,
  input  logic                                 arst_n,
  input  logic                                 i_halt,
  input  logic                                 i_initiate,
  input  logic [ADDR_WIDTH-1:0]                i_miss_addr,
  output logic                                 o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0]                o_mem_req_addr,
  input  logic                                 i_mem_req_ready,
  input  logic                                 i_mem_rsp_valid,
  input  logic [WORD_WIDTH-1:0]                i_mem_rsp_data,
  output logic                                 o_mem_rsp_ready,
  output logic                                 o_crit_valid,
  output logic [WORD_WIDTH-1:0]                o_crit_word,
  output logic                                 o_line_valid,
  output logic [ADDR_WIDTH-1:0]                o_line_addr,
  output logic [WORDS_PER_LINE*WORD_WIDTH-1:0] o_line_data,
  input  logic                                 i_line_ready,
  output logic                                 o_busy
);

  localparam int unsigned OFS_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned CNT_W = OFS_W + 1;
  localparam logic [CNT_W-1:0] LINE_WORDS = CNT_W'(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]       rsp_cnt_q, rsp_cnt_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [OFS_W-1:0]       miss_ofs_q, miss_ofs_d;
  logic                   crit_pend_q, crit_pend_d;
  logic [WORD_WIDTH-1:0]  line_buf_q [WORDS_PER_LINE];
  logic [WORD_WIDTH-1:0]  line_buf_d [WORDS_PER_LINE];

  logic [OFS_W-1:0]       start_ofs;
  logic [OFS_W-1:0]       req_ofs;
  logic [OFS_W-1:0]       rsp_slot;

`ifdef ICACHE_REFILL_CWF_EN
  assign start_ofs = miss_ofs_q;
`else
  assign start_ofs = '0;
`endif

  // Offsets wrap inside the line by truncation to OFS_W bits.
  assign req_ofs  = start_ofs + req_cnt_q[OFS_W-1:0];
  assign rsp_slot = start_ofs + rsp_cnt_q[OFS_W-1:0];

  assign o_mem_req_addr = base_q | ADDR_WIDTH'(req_ofs);
  assign o_line_addr    = base_q;
  assign o_busy         = (state_q != StIdle);
  // The critical word always lands in the slot of the missed offset.
  assign o_crit_word    = line_buf_q[miss_ofs_q];

  always_comb begin
    o_line_data = '0;
    for (int k = 0; k < WORDS_PER_LINE; k++) begin
      o_line_data[k*WORD_WIDTH +: WORD_WIDTH] = line_buf_q[k];
    end
  end

  always_comb begin
    state_d         = state_q;
    req_cnt_d       = req_cnt_q;
    rsp_cnt_d       = rsp_cnt_q;
    base_d          = base_q;
    miss_ofs_d      = miss_ofs_q;
    crit_pend_d     = crit_pend_q;
    line_buf_d      = line_buf_q;
    o_mem_req_valid = 1'b0;
    o_mem_rsp_ready = 1'b0;
    o_line_valid    = 1'b0;

    // A pending pulse is held back through halt and retires on its first visible cycle.
    o_crit_valid = crit_pend_q & ~i_halt;
    if (o_crit_valid) begin
      crit_pend_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (i_initiate && !i_halt) begin
          state_d    = StFill;
          base_d     = {i_miss_addr[ADDR_WIDTH-1:OFS_W], {OFS_W{1'b0}}};
          miss_ofs_d = i_miss_addr[OFS_W-1:0];
          req_cnt_d  = '0;
          rsp_cnt_d  = '0;
        end
      end
      StFill: begin
        o_mem_req_valid = (req_cnt_q < LINE_WORDS) && !i_halt;
        o_mem_rsp_ready = (rsp_cnt_q < req_cnt_q) && !i_halt;
        if (o_mem_req_valid && i_mem_req_ready) begin
          req_cnt_d = req_cnt_q + 1'b1;
        end
        if (o_mem_rsp_ready && i_mem_rsp_valid) begin
          line_buf_d[rsp_slot] = i_mem_rsp_data;
          rsp_cnt_d            = rsp_cnt_q + 1'b1;
`ifdef ICACHE_REFILL_CWF_EN
          if (rsp_cnt_q == '0) begin
            crit_pend_d = 1'b1;
          end
`endif
          if (rsp_cnt_q == LAST_WORD) begin
            state_d = StDone;
`ifndef ICACHE_REFILL_CWF_EN
            crit_pend_d = 1'b1;
`endif
          end
        end
      end
      StDone: begin
        o_line_valid = !i_halt;
        if (o_line_valid && i_line_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q     <= StIdle;
      req_cnt_q   <= '0;
      rsp_cnt_q   <= '0;
      base_q      <= '0;
      miss_ofs_q  <= '0;
      crit_pend_q <= 1'b0;
      line_buf_q  <= '{default: '0};
    end else begin
      state_q     <= state_d;
      req_cnt_q   <= req_cnt_d;
      rsp_cnt_q   <= rsp_cnt_d;
      base_q      <= base_d;
      miss_ofs_q  <= miss_ofs_d;
      crit_pend_q <= crit_pend_d;
      line_buf_q  <= line_buf_d;
    end
  end

endmodule

// File: tb/tb_icache_refill_sequencer.sv
// Self-checking bench for icache_refill_sequencer: directed scenarios plus randomized refills
// checked against a queue-based transaction model of the refill protocol.
module tb_icache_refill_sequencer;

  localparam int unsigned AW  = 32;
  localparam int unsigned WW  = 32;
  localparam int unsigned WPL = 4;
  localparam int unsigned LW  = WPL * WW;
`ifdef ICACHE_REFILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          arst_n;
  logic          i_halt;
  logic          i_initiate;
  logic [AW-1:0] i_miss_addr;
  logic          o_mem_req_valid;
  logic [AW-1:0] o_mem_req_addr;
  logic          i_mem_req_ready;
  logic          i_mem_rsp_valid;
  logic [WW-1:0] i_mem_rsp_data;
  logic          o_mem_rsp_ready;
  logic          o_crit_valid;
  logic [WW-1:0] o_crit_word;
  logic          o_line_valid;
  logic [AW-1:0] o_line_addr;
  logic [LW-1:0] o_line_data;
  logic          i_line_ready;
  logic          o_busy;

  always #5 clk = ~clk;

  icache_refill_sequencer #(
    .ADDR_WIDTH    (AW),
    .WORD_WIDTH    (WW),
    .WORDS_PER_LINE(WPL)
  ) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .i_halt         (i_halt),
    .i_initiate     (i_initiate),
    .i_miss_addr    (i_miss_addr),
    .o_mem_req_valid(o_mem_req_valid),
    .o_mem_req_addr (o_mem_req_addr),
    .i_mem_req_ready(i_mem_req_ready),
    .i_mem_rsp_valid(i_mem_rsp_valid),
    .i_mem_rsp_data (i_mem_rsp_data),
    .o_mem_rsp_ready(o_mem_rsp_ready),
    .o_crit_valid   (o_crit_valid),
    .o_crit_word    (o_crit_word),
    .o_line_valid   (o_line_valid),
    .o_line_addr    (o_line_addr),
    .o_line_data    (o_line_data),
    .i_line_ready   (i_line_ready),
    .o_busy         (o_busy)
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level model: 0 idle, 1 filling, 2 line held.
  int            phase = 0;
  logic [AW-1:0] m_base, m_miss;
  logic [AW-1:0] exp_req[$];
  logic [AW-1:0] pend_addr[$];
  int            pend_cyc[$];
  int            rsp_seen = 0;
  int            req_acc = 0;
  bit            crit_due = 1'b0;
  logic [WW-1:0] salt = '0;
  int            cyc = 0;
  int            init_cyc, line_first_cyc, crit_cyc;

  // Stimulus knobs.
  int req_mode = 0;
  int halt_pct = 0;
  int rsp_pct = 100;
  int lr_pct = 100;
  int init_pct = 0;
  int hold_done = 0;
  int halt_at_req = -1;

  function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
    return WW'(a) ^ salt;
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_start(input logic [AW-1:0] addr);
    int s;
    m_miss   = addr;
    m_base   = addr & ~AW'(WPL - 1);
    s        = CWF ? int'(addr % WPL) : 0;
    exp_req.delete();
    for (int k = 0; k < WPL; k++) begin
      exp_req.push_back(m_base + AW'((s + k) % WPL));
    end
    rsp_seen = 0;
    req_acc  = 0;
    phase    = 1;
  endtask

  // One clock cycle: inputs already driven just after the previous edge.
  task automatic tick();
    bit            exp_rv, exp_rr, req_hs, rsp_hs;
    logic [LW-1:0] exp_line;
    i_mem_rsp_valid = (pend_addr.size() > 0) && (pend_cyc[0] < cyc) &&
                      (int'($urandom_range(99)) < rsp_pct);
    i_mem_rsp_data  = i_mem_rsp_valid ? mem_word(pend_addr[0]) : WW'($urandom());
    #4;
    exp_rv = (phase == 1) && (exp_req.size() > 0) && !i_halt;
    exp_rr = (phase == 1) && (pend_addr.size() > 0) && !i_halt;
    check("busy", LW'(o_busy), LW'(phase != 0));
    check("req_valid", LW'(o_mem_req_valid), LW'(exp_rv));
    if (exp_rv) check("req_addr", LW'(o_mem_req_addr), LW'(exp_req[0]));
    check("rsp_ready", LW'(o_mem_rsp_ready), LW'(exp_rr));
    check("line_valid", LW'(o_line_valid), LW'((phase == 2) && !i_halt));
    check("crit_valid", LW'(o_crit_valid), LW'(crit_due && !i_halt));
    if (crit_due && !i_halt) begin
      check("crit_word", LW'(o_crit_word), LW'(mem_word(m_miss)));
      if (crit_cyc < 0) crit_cyc = cyc;
    end
    if (phase == 2) begin
      for (int k = 0; k < WPL; k++) exp_line[k*WW +: WW] = mem_word(m_base + AW'(k));
      check("line_data", o_line_data, exp_line);
      check("line_addr", LW'(o_line_addr), LW'(m_base));
      if (!i_halt && line_first_cyc < 0) line_first_cyc = cyc;
    end
    req_hs = exp_rv && i_mem_req_ready;
    rsp_hs = exp_rr && i_mem_rsp_valid;
    @(posedge clk);
    if (!arst_n) begin
      phase    = 0;
      crit_due = 1'b0;
      exp_req.delete();
      pend_addr.delete();
      pend_cyc.delete();
    end else begin
      if (crit_due && !i_halt) crit_due = 1'b0;
      case (phase)
        0: if (i_initiate && !i_halt) model_start(i_miss_addr);
        1: begin
          if (req_hs) begin
            pend_addr.push_back(exp_req.pop_front());
            pend_cyc.push_back(cyc);
            req_acc++;
          end
          if (rsp_hs) begin
            void'(pend_addr.pop_front());
            void'(pend_cyc.pop_front());
            rsp_seen++;
            if (CWF && rsp_seen == 1) crit_due = 1'b1;
            if (rsp_seen == WPL) begin
              phase = 2;
              if (!CWF) crit_due = 1'b1;
            end
          end
        end
        2: if (!i_halt && i_line_ready) phase = 0;
        default: phase = 0;
      endcase
    end
    #1;
    cyc++;
  endtask

  task automatic run_refill(input logic [AW-1:0] addr, input int rst_after);
    int n = 0;
    int done_cnt = 0;
    int halt_left = 0;
    bit halted_once = 1'b0;
    i_initiate     = 1'b1;
    i_miss_addr    = addr;
    i_halt         = 1'b0;
    arst_n         = 1'b1;
    init_cyc       = cyc;
    line_first_cyc = -1;
    crit_cyc       = -1;
    tick();
    while (phase != 0 && n < 200) begin
      i_mem_req_ready = (req_mode == 0) ? 1'b1 : (req_mode == 1) ? (n % 2 == 0) :
                        1'($urandom_range(1));
      i_halt = (int'($urandom_range(99)) < halt_pct);
      if (halt_at_req >= 0 && req_acc == halt_at_req && !halted_once) begin
        halt_left   = 3;
        halted_once = 1'b1;
      end
      if (halt_left > 0) begin
        i_halt = 1'b1;
        halt_left--;
      end
      i_line_ready = (int'($urandom_range(99)) < lr_pct);
      i_initiate   = (int'($urandom_range(99)) < init_pct);
      i_miss_addr  = $urandom();
      if (phase == 2 && hold_done > 0) begin
        if (done_cnt < hold_done) i_line_ready = 1'b0;
        else i_line_ready = 1'b1;
        i_initiate = (done_cnt == 2);
        done_cnt++;
      end
      arst_n = !(rst_after >= 0 && rsp_seen == rst_after);
      tick();
      n++;
    end
    i_initiate = 1'b0;
    i_halt     = 1'b0;
    arst_n     = 1'b1;
    total++;
    assert (n < 200) else begin
      bad++;
      $error("FAIL refill_timeout: observed=%0d cycles expected<200", n);
    end
  endtask

  task automatic set_knobs(input int rm, input int hp, input int rp, input int lp);
    req_mode    = rm;
    halt_pct    = hp;
    rsp_pct     = rp;
    lr_pct      = lp;
    init_pct    = 0;
    hold_done   = 0;
    halt_at_req = -1;
  endtask

  initial begin
    arst_n          = 1'b0;
    i_halt          = 1'b0;
    i_initiate      = 1'b0;
    i_miss_addr     = '0;
    i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b0;
    i_mem_rsp_data  = '0;
    i_line_ready    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    tick();
    check("reset_busy", LW'(o_busy), '0);
    arst_n = 1'b1;
    tick();

    // Wrap/linear order with data = address and ideal memory timing.
    set_knobs(0, 0, 100, 100);
    salt = '0;
    run_refill(32'h102, -1);
    check("line_latency", LW'(line_first_cyc - init_cyc), LW'(WPL + 2));
    check("crit_latency", LW'(crit_cyc - init_cyc), LW'(CWF ? 3 : WPL + 2));
    tick();

    // Request backpressure toggling 1,0,1,0.
    set_knobs(1, 0, 100, 100);
    salt = 32'h5a5a_0000;
    run_refill(32'h0000_3457, -1);
    tick();

    // Halt for 3 cycles after the second request is accepted.
    set_knobs(0, 0, 70, 100);
    halt_at_req = 2;
    run_refill(32'h0000_0a1d, -1);

    // Held line with an initiate pulse that must be ignored.
    set_knobs(2, 0, 100, 100);
    hold_done = 5;
    run_refill(32'h0000_7f01, -1);
    tick();

    // Reset after two responses, then a fresh refill.
    set_knobs(0, 0, 100, 100);
    run_refill(32'h0000_0553, 2);
    tick();
    check("post_reset_busy", LW'(o_busy), '0);
    salt = '0;
    run_refill(32'h200, -1);

    // Randomized back-to-back refills.
    for (int t = 0; t < 30; t++) begin
      set_knobs(int'($urandom_range(2)), int'($urandom_range(30)), int'($urandom_range(100, 30)),
                int'($urandom_range(100, 20)));
      init_pct = int'($urandom_range(30));
      salt     = $urandom();
      run_refill($urandom(), ($urandom_range(5) == 0) ? int'($urandom_range(3)) : -1);
      if ($urandom_range(1) == 1) tick();
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_refill_sequencer.md
# icache_refill_sequencer

Sequences a single cache-line refill between the instruction-cache control unit and the memory interface. Each refill starts on a one-cycle initiate pulse from the control unit carrying the missed word address. The block issues one word-read request per line word, in critical-word-first wrap order, and collects the in-order responses into a line buffer. It then presents the assembled line to the tag/data array updater, and it freezes on the shared `i_halt` stall.

## Interface
- `ADDR_WIDTH`, 32, word-address width.
- `WORD_WIDTH`, 32, data word width.
- `WORDS_PER_LINE`, 4, words per cache line; power of two, ≥2. `OFS_W = $clog2(WORDS_PER_LINE)`.

- `clk`  in  1  clock; all logic on rising edge.
- `arst_n`  in  1  reset, synchronous and active-low.
- `i_halt`  in  1  global stall; freezes all state.
- `i_initiate`  in  1  one-cycle refill start pulse from control unit.
- `i_miss_addr`  in  ADDR_WIDTH  missed word address; sampled with `i_initiate`.
- `o_mem_req_valid`  out  1  word-read request valid.
- `o_mem_req_addr`  out  ADDR_WIDTH  requested word address.
- `i_mem_req_ready`  in  1  memory accepts request.
- `i_mem_rsp_valid`  in  1  read data valid; responses return in request order.
- `i_mem_rsp_data`  in  WORD_WIDTH  read data.
- `o_mem_rsp_ready`  out  1  sequencer accepts response.
- `o_crit_valid`  out  1  one-cycle pulse: `o_crit_word` valid.
- `o_crit_word`  out  WORD_WIDTH  missed word.
- `o_line_valid`  out  1  assembled line available.
- `o_line_addr`  out  ADDR_WIDTH  line-aligned base address (low OFS_W bits zero).
- `o_line_data`  out  WORDS_PER_LINE*WORD_WIDTH  line; word k at bits [k*WORD_WIDTH +: WORD_WIDTH].
- `i_line_ready`  in  1  array updater consumes line.
- `o_busy`  out  1  refill in progress (state ≠ IDLE).

## Operation
- States: IDLE, FILL, DONE.
- IDLE → FILL:
  - Trigger: `i_initiate & ~i_halt`.
  - Latch the base line address and start offset `s = i_miss_addr[OFS_W-1:0]`.
  - Clear `req_cnt` and `rsp_cnt`, each OFS_W+1 bits.
- FILL, request side:
  - `o_mem_req_valid = (req_cnt < WORDS_PER_LINE) & ~i_halt`.
  - `o_mem_req_addr = base | ((s + req_cnt) mod WORDS_PER_LINE)`; the offset wraps inside the line.
  - `req_cnt` increments on `o_mem_req_valid & i_mem_req_ready`.
  - Requests are pipelined; there is no wait for a response before the next request.
- FILL, response side:
  - `o_mem_rsp_ready = (rsp_cnt < req_cnt) & ~i_halt`.
  - On a response handshake, write the data to buffer slot `(s + rsp_cnt) mod WORDS_PER_LINE`, then increment `rsp_cnt`.
- FILL → DONE: on the handshake that makes `rsp_cnt == WORDS_PER_LINE`.
- DONE:
  - `o_line_valid = ~i_halt`.
  - On `o_line_valid & i_line_ready`, go to IDLE.
- `i_initiate` is ignored outside IDLE.
- `o_line_data` and `o_line_addr` are stable from DONE entry until consumed. Buffer contents are don't-care in other states.
- `i_halt` high has these effects:
  - No state or counter change.
  - `o_mem_req_valid`, `o_mem_rsp_ready`, `o_line_valid` and `o_crit_valid` forced 0.
  - Any pending `o_crit_valid` pulse is deferred to the first un-halted cycle.
  - `o_busy` still reflects state.
- Reset (`arst_n` low at an edge), including mid-refill:
  - State → IDLE; `req_cnt` and `rsp_cnt` → 0; no pending crit pulse.
  - Outputs `o_mem_req_valid`, `o_mem_rsp_ready`, `o_crit_valid`, `o_line_valid`, `o_busy` = 0.
  - `o_mem_req_addr`, `o_line_addr`, `o_line_data` and `o_crit_word` are don't-care. Registered copies reset to 0.
  - In-flight memory responses are dropped (`o_mem_rsp_ready` = 0).
- A simultaneous request and response handshake in one cycle updates both counters.

## Timing
- `i_initiate` at edge 0 → `o_mem_req_valid` high from cycle 1; `o_busy` high from cycle 1.
- With `i_mem_req_ready` tied 1: one request per cycle, issued cycles 1..WORDS_PER_LINE.
- With responses one cycle after request acceptance: last response accepted cycle WORDS_PER_LINE+1, `o_line_valid` at cycle WORDS_PER_LINE+2.
- `o_crit_valid` is a registered pulse, one cycle after the triggering event defined under Configuration.
- `o_busy` falls the cycle after the line handshake. A new `i_initiate` is accepted in that same cycle.

## Configuration
- `ICACHE_REFILL_CWF_EN` defined:
  - Start offset `s` = miss offset (critical-word-first, wrap order).
  - `o_crit_valid` pulses the cycle after the first response handshake.
  - `o_crit_word` = that response.
- Not defined:
  - `s` forced to 0 (linear order from the line base).
  - `o_crit_valid` pulses together with the first cycle of `o_line_valid`.
  - `o_crit_word` = buffer slot `i_miss_addr[OFS_W-1:0]`.

## Test plan
- **CWF order:** CWF_EN, WORDS_PER_LINE=4, `i_miss_addr=0x102`, memory always ready, data = addr.
  - Requests 0x102, 0x103, 0x100, 0x101.
  - `o_crit_word=0x102`.
  - `o_line_data` words {0x100, 0x101, 0x102, 0x103} at slots 0..3.
  - `o_line_addr=0x100`.
- **Linear order:** same without CWF_EN.
  - Requests 0x100..0x103.
  - `o_crit_valid` with `o_line_valid`, `o_crit_word=0x102`.
- **Backpressure:** `i_mem_req_ready` toggles 1,0,1,0…
  - Exactly 4 requests issued; `o_mem_req_addr` holds while not accepted.
  - Line valid only after the 4th response.
- **Halt mid-fill:** `i_halt` high 3 cycles after the second request.
  - No handshakes or state change during the halt.
  - Refill completes with the correct line afterwards.
- **Held line / ignored initiate:** in DONE with `i_line_ready=0` for 5 cycles, pulse `i_initiate`.
  - Initiate ignored; `o_line_data` stable.
  - Return to IDLE after the line handshake.
- **Reset mid-fill:** `arst_n` low after 2 responses.
  - All outputs 0 next cycle; `o_busy=0`.
  - A fresh refill of 0x200 then completes normally.
